alu_seq_unit: RTL and testbench

- Parametrised, handshaked successor to the board-level 16-bit ALU datapath.
- Single-cycle ops: ADD/SUB/logic/shift/compare.
- Iterative multi-cycle ops: multiply, divide and remainder.
- Sits between the switch/key capture logic (or a future bus master) and the LED/result sink; registered result and flags.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_muldiv.sv | 84 ++++++++
 rtl/alu_seq_unit.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcode values, FSM state type and opcode classification
// for the sequential ALU (alu_seq_unit) and its mul/div engine.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_SAR   = 4'h8;
  localparam logic [3:0] OP_SLT   = 4'h9;
  localparam logic [3:0] OP_MUL   = 4'hA;
  localparam logic [3:0] OP_DIV   = 4'hB;
  localparam logic [3:0] OP_MOD   = 4'hC;
  localparam logic [3:0] OP_INC   = 4'hD;
  localparam logic [3:0] OP_DEC   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative engine, one shift-add (MUL) or one restoring
// subtract (DIV/MOD) step per cycle, WIDTH steps per operation.
// Ports:
//   clk, rst     clock, synchronous active-high reset (aborts any operation)
//   start        load operands and begin (ignored while not idle by the caller)
//   op           opcode; OP_DIV/OP_MOD select divide, anything else multiply
//   a, b         operands
//   done         high during the final step cycle; lo/rem/carry valid then
//   lo           product low half / quotient
//   rem          product high half / remainder
//   carry        product high half nonzero
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rem,
  output logic             carry
);

  // p_q = {high/remainder, low/quotient}
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   cnt_q;
  logic               busy_q;
  logic               div_q;

  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     rsh_s;
  logic [WIDTH:0]     sub_s;
  logic               ge_s;

  always_comb begin
    add_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    rsh_s = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    sub_s = rsh_s - {1'b0, opnd_q};
    ge_s  = (rsh_s >= {1'b0, opnd_q});
    p_d   = '0;
    if (div_q) begin
      // Partial remainder stays below the divisor, so WIDTH bits hold it.
      p_d = {(ge_s ? sub_s[WIDTH-1:0] : rsh_s[WIDTH-1:0]), p_q[WIDTH-2:0], ge_s};
    end else begin
      p_d = {add_s, p_q[WIDTH-1:1]};
    end
  end

  // Outputs come from the step being taken so the caller can capture them
  // on the same edge that finishes the operation.
  assign done  = busy_q && (cnt_q == '0);
  assign lo    = p_d[WIDTH-1:0];
  assign rem   = p_d[2*WIDTH-1:WIDTH];
  assign carry = |p_d[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (start) begin
      div_q  <= (op == OP_DIV) || (op == OP_MOD);
      p_q    <= {{WIDTH{1'b0}}, ((op == OP_DIV) || (op == OP_MOD)) ? a : b};
      opnd_q <= ((op == OP_DIV) || (op == OP_MOD)) ? b : a;
      cnt_q  <= WIDTH'(WIDTH - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      p_q   <= p_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked ALU with single-cycle ops inline and MUL/DIV/MOD
// delegated to alu_seq_muldiv. Result and flags are registered and held
// until the consumer takes them.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      operation handshake (a, b, opcode captured on accept)
//   out_valid/out_ready    result handshake
//   result                 registered result
//   flag_carry             carry/borrow/last shifted-out bit; MUL high half nonzero
//   flag_overflow          signed overflow for ADD/SUB/INC/DEC
//   flag_zero, flag_neg    from the final result
//   flag_div0              DIV/MOD with b == 0
//   flag_illegal           MUL/DIV/MOD with MULDIV_EN == 0
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_carry,
  output logic             flag_overflow,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_div0,
  output logic             flag_illegal
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, zero_q, neg_q, div0_q, ill_q;
  logic [3:0]       op_q;

  logic               accept, go_busy;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     sum_c, dif_c, shl_c, shr_c;
  logic signed [WIDTH:0] sar_c;
  logic [WIDTH-1:0]   res_c;
  logic               carry_c, ovf_c, div0_c, ill_c;

  logic               md_done, md_carry;
  logic [WIDTH-1:0]   md_lo, md_rem, md_res;

  assign accept  = (state_q == S_IDLE) && in_valid && in_ready_q;
  // Divide by zero and disabled ops finish in one cycle without the engine.
  assign go_busy = MULDIV_EN && is_multicycle(opcode) && ((opcode == OP_MUL) || (b != '0));
  assign shamt   = b[SW-1:0];

  always_comb begin
    sum_c   = {1'b0, a} + {1'b0, b};
    dif_c   = {1'b0, a} - {1'b0, b};
    // Extra bit on the shifted-out side captures the last bit lost (0 when amount is 0).
    shl_c   = {1'b0, a} << shamt;
    shr_c   = {a, 1'b0} >> shamt;
    sar_c   = $signed({a, 1'b0}) >>> shamt;
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    div0_c  = 1'b0;
    ill_c   = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_c   = sum_c[WIDTH-1:0];
        carry_c = sum_c[WIDTH];
        ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (res_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = dif_c[WIDTH-1:0];
        carry_c = dif_c[WIDTH];
        ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (res_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_XOR: res_c = a ^ b;
      OP_NOT: res_c = ~a;
      OP_SHL: begin
        res_c   = shl_c[WIDTH-1:0];
        carry_c = shl_c[WIDTH];
      end
      OP_SHR: begin
        res_c   = shr_c[WIDTH:1];
        carry_c = shr_c[0];
      end
      OP_SAR: begin
        res_c   = sar_c[WIDTH:1];
        carry_c = sar_c[0];
      end
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MUL, OP_DIV, OP_MOD: begin
        if (!MULDIV_EN) begin
          ill_c = 1'b1;
        end else if (b == '0) begin
          div0_c = 1'b1;
          res_c  = (opcode == OP_MOD) ? a : '1;
        end
      end
      OP_INC: begin
        res_c = a + 1'b1;
        ovf_c = !a[WIDTH-1] && res_c[WIDTH-1];
      end
      OP_DEC: begin
        res_c = a - 1'b1;
        ovf_c = a[WIDTH-1] && !res_c[WIDTH-1];
      end
      OP_PASSB: res_c = b;
      default: res_c = '0;
    endcase
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (accept && go_busy),
    .op    (opcode),
    .a     (a),
    .b     (b),
    .done  (md_done),
    .lo    (md_lo),
    .rem   (md_rem),
    .carry (md_carry)
  );

  assign md_res = (op_q == OP_MOD) ? md_rem : md_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      div0_q      <= 1'b0;
      ill_q       <= 1'b0;
      op_q        <= OP_ADD;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            op_q       <= opcode;
            if (go_busy) begin
              state_q <= S_BUSY;
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_c;
              carry_q     <= carry_c;
              ovf_q       <= ovf_c;
              zero_q      <= (res_c == '0);
              neg_q       <= res_c[WIDTH-1];
              div0_q      <= div0_c;
              ill_q       <= ill_c;
            end
          end
        end
        S_BUSY: begin
          if (md_done) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_res;
            carry_q     <= (op_q == OP_MUL) && md_carry;
            ovf_q       <= 1'b0;
            zero_q      <= (md_res == '0);
            neg_q       <= md_res[WIDTH-1];
            div0_q      <= 1'b0;
            ill_q       <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            // Ready rises on the same edge valid falls: 2-cycle issue interval.
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign flag_carry    = carry_q;
  assign flag_overflow = ovf_q;
  assign flag_zero     = zero_q;
  assign flag_neg      = neg_q;
  assign flag_div0     = div0_q;
  assign flag_illegal  = ill_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: directed vectors with hand-computed results, flags and
// latencies for alu_seq_unit at WIDTH=16.
module tb_alu_seq_unit;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a, b;
  logic [3:0]  opcode;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        flag_carry, flag_overflow, flag_zero, flag_neg, flag_div0, flag_illegal;

  int errors = 0;
  int checks = 0;

  alu_seq_unit #(.WIDTH(16), .MULDIV_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .opcode        (opcode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .flag_carry    (flag_carry),
    .flag_overflow (flag_overflow),
    .flag_zero     (flag_zero),
    .flag_neg      (flag_neg),
    .flag_div0     (flag_div0),
    .flag_illegal  (flag_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] flags();
    return {flag_carry, flag_overflow, flag_zero, flag_neg, flag_div0, flag_illegal};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait for out_valid; checks latency, ready-low while
  // waiting, result and flags {carry,ovf,zero,neg,div0,ill}. Leaves result pending.
  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] x,
                       input logic [15:0] y, input int exp_lat,
                       input logic [15:0] exp_res, input logic [5:0] exp_flg);
    int n;
    int lat;
    logic rdy_seen;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, ":ready"}, {31'd0, in_ready}, 32'd1);
    opcode   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'h0BAD;
    opcode   = OP_PASSB;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      rdy_seen |= in_ready;
      tick();
      lat++;
    end
    rdy_seen |= in_ready;
    check_eq({tag, ":lat"}, lat, exp_lat);
    check_eq({tag, ":rdy_low"}, {31'd0, rdy_seen}, 32'd0);
    check_eq({tag, ":res"}, {16'd0, result}, {16'd0, exp_res});
    check_eq({tag, ":flags"}, {26'd0, flags()}, {26'd0, exp_flg});
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, ":drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = OP_ADD;
    tick();
    tick();
    check_eq("rst:ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst:valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst:res", {16'd0, result}, 32'd0);
    check_eq("rst:flags", {26'd0, flags()}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rst:ready_after", {31'd0, in_ready}, 32'd1);

    issue("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 6'b101000); take("add_wrap");
    issue("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 6'b010100); take("add_ovf");
    issue("sub_brw",  OP_SUB, 16'h0003, 16'h0005, 1, 16'hFFFE, 6'b100100); take("sub_brw");
    issue("mul_hi",   OP_MUL, 16'h0100, 16'h0100, 17, 16'h0000, 6'b101000); take("mul_hi");
    issue("mul_sm",   OP_MUL, 16'h0003, 16'h0005, 17, 16'h000F, 6'b000000); take("mul_sm");
    issue("mul_max",  OP_MUL, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 6'b100000); take("mul_max");
    issue("div",      OP_DIV, 16'd1000, 16'd7, 17, 16'd142, 6'b000000); take("div");
    issue("mod",      OP_MOD, 16'd1000, 16'd7, 17, 16'd6, 6'b000000); take("mod");
    issue("div0",     OP_DIV, 16'd5, 16'd0, 1, 16'hFFFF, 6'b000110); take("div0");
    issue("mod0",     OP_MOD, 16'd5, 16'd0, 1, 16'h0005, 6'b000010); take("mod0");
    issue("shl",      OP_SHL, 16'h8001, 16'h0001, 1, 16'h0002, 6'b100000); take("shl");
    issue("shl0",     OP_SHL, 16'h1234, 16'h0000, 1, 16'h1234, 6'b000000); take("shl0");
    issue("shr",      OP_SHR, 16'h0003, 16'h0001, 1, 16'h0001, 6'b100000); take("shr");
    issue("slt_t",    OP_SLT, 16'hFFFF, 16'h0001, 1, 16'h0001, 6'b000000); take("slt_t");
    issue("slt_f",    OP_SLT, 16'h0001, 16'hFFFF, 1, 16'h0000, 6'b001000); take("slt_f");
    issue("inc",      OP_INC, 16'h7FFF, 16'h0000, 1, 16'h8000, 6'b010100); take("inc");
    issue("dec",      OP_DEC, 16'h8000, 16'h0000, 1, 16'h7FFF, 6'b010000); take("dec");
    issue("xor",      OP_XOR, 16'hF0F0, 16'hFF00, 1, 16'h0FF0, 6'b000000); take("xor");
    issue("not",      OP_NOT, 16'h00FF, 16'h0000, 1, 16'hFF00, 6'b000100); take("not");
    issue("passb",    OP_PASSB, 16'h1234, 16'h0000, 1, 16'h0000, 6'b001000); take("passb");

    // Backpressure: result must hold and new requests must be refused.
    issue("sar", OP_SAR, 16'h8001, 16'h0001, 1, 16'hC000, 6'b100100);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      opcode   = OP_ADD;
      a        = 16'h0001;
      b        = 16'h0001;
      in_valid = (i % 2 == 0);
      tick();
      check_eq("hold:res", {16'd0, result}, 32'h0000C000);
      seen |= in_ready | !out_valid;
    end
    in_valid = 1'b0;
    check_eq("hold:hs", {31'd0, seen}, 32'd0);
    check_eq("hold:flags", {26'd0, flags()}, {26'd0, 6'b100100});
    take("sar");
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= out_valid;
    end
    check_eq("hold:no_ghost", {31'd0, seen}, 32'd0);

    // Reset in BUSY cycle 8 of a DIV.
    opcode   = OP_DIV;
    a        = 16'd1000;
    b        = 16'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_eq("abort:busy", {31'd0, out_valid | in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    check_eq("abort:valid", {31'd0, out_valid}, 32'd0);
    check_eq("abort:res", {16'd0, result}, 32'd0);
    check_eq("abort:ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("abort:ready_after", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen |= out_valid;
    end
    check_eq("abort:no_stale", {31'd0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
